// File: rtl/rv32_imm_pkg.sv
// rtl/rv32_imm_pkg.sv - shared encodings for the decode-stage immediate scheduler
package rv32_imm_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        IMM_U     = 3'b000,
        IMM_J     = 3'b001,
        IMM_I     = 3'b010,
        IMM_B     = 3'b011,
        IMM_S     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_NONE  = 3'b111
    } imm_type_e;

    // Bit position of the zero-extend flag inside IMM_SEL
    localparam int IMM_ZEXT = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [3:0] make_sel(input logic zext, input imm_type_e ty);
        return {zext, ty};
    endfunction

endpackage

// File: rtl/imm_type_decode.sv
// rtl/imm_type_decode.sv - combinational opcode classifier and immediate former
module imm_type_decode
    import rv32_imm_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  imm_sel,
    output logic        illegal,
    output logic [31:0] imm
);

    imm_type_e ty;
    logic      zext;
    logic      s;

    assign s = inst[31];

    always_comb begin
        ty      = IMM_NONE;
        zext    = 1'b0;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:             ty = IMM_U;
            OPC_JAL:                        ty = IMM_J;
            OPC_JALR, OPC_LOAD:             ty = IMM_I;
            OPC_BRANCH:                     ty = IMM_B;
            OPC_STORE:                      ty = IMM_S;
            OPC_OP_IMM: begin
                // Shifts carry a 5-bit unsigned shamt; SLTIU still uses the sign-extended I form
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
                    ty   = IMM_SHAMT;
                    zext = 1'b1;
                end else begin
                    ty = IMM_I;
                end
            end
            OPC_OP, OPC_SYSTEM, OPC_FENCE:  ty = IMM_NONE;
            default:                        illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = 32'h0;
        case (ty)
            IMM_U:     imm = {inst[31:12], 12'b0};
            IMM_J:     imm = {{12{s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_I:     imm = {{20{s}}, inst[31:20]};
            IMM_B:     imm = {{20{s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_S:     imm = {{20{s}}, inst[31:25], inst[11:7]};
            IMM_SHAMT: imm = {27'b0, inst[24:20]};
            default:   imm = 32'h0;
        endcase
    end

    assign imm_sel = make_sel(zext, ty);

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode-stage immediate scheduler with 2-entry skid buffer
module imm_decode_stage
    import rv32_imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INST_IN,
    input  logic [PC_W-1:0] PC_IN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [31:0]     INST_OUT,
    output logic [PC_W-1:0] PC_OUT,
    output logic [3:0]      IMM_SEL,
    output logic [XLEN-1:0] IMM_OUT,
    output logic            ILLEGAL
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [3:0]      sel;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        inst: NOP, pc: '0, sel: make_sel(1'b0, IMM_NONE), imm: '0, illegal: 1'b0
    };

    occ_e   state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;

    logic   [3:0]  dec_sel;
    logic          dec_ill;
    logic   [31:0] dec_imm;
    entry_t        new_entry;
    logic          push, pop;

    imm_type_decode u_dec (
        .inst    (INST_IN),
        .imm_sel (dec_sel),
        .illegal (dec_ill),
        .imm     (dec_imm)
    );

    always_comb begin
        new_entry = '{inst: INST_IN, pc: PC_IN, sel: dec_sel, imm: dec_imm, illegal: dec_ill};
        push      = IN_VALID & in_ready_q;
        pop       = out_valid_q & OUT_READY;
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (FLUSH) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        state_d = OCC_TWO;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != OCC_TWO);
        out_valid_d = (state_d != OCC_EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= OCC_EMPTY;
            head_q      <= RESET_ENTRY;
            tail_q      <= RESET_ENTRY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign INST_OUT  = head_q.inst;
    assign PC_OUT    = head_q.pc;
    assign IMM_SEL   = head_q.sel;
    assign IMM_OUT   = head_q.imm;
    assign ILLEGAL   = head_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized self-checking bench with a queue-based reference model
module tb_imm_decode_stage;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, ILLEGAL;
    logic [31:0] INST_IN, PC_IN, INST_OUT, PC_OUT, IMM_OUT;
    logic [3:0]  IMM_SEL;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t model_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INST_IN(INST_IN), .PC_IN(PC_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .INST_OUT(INST_OUT), .PC_OUT(PC_OUT),
        .IMM_SEL(IMM_SEL), .IMM_OUT(IMM_OUT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Reference decode straight from the ISA field layout, using signed arithmetic for extension
    function automatic void ref_decode(input logic [31:0] i, output logic [3:0] sel,
                                       output logic [31:0] imm, output logic ill);
        logic [6:0]  op;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [11:0] s12;
        op  = i[6:0];
        ill = 1'b0;
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        s12 = {i[31:25], i[11:7]};
        if (op == 7'h37 || op == 7'h17) begin
            sel = 4'h0; imm = i & 32'hFFFF_F000;
        end else if (op == 7'h6F) begin
            sel = 4'h1; imm = 32'($signed(j21));
        end else if (op == 7'h67 || op == 7'h03) begin
            sel = 4'h2; imm = 32'($signed(i) >>> 20);
        end else if (op == 7'h63) begin
            sel = 4'h3; imm = 32'($signed(b13));
        end else if (op == 7'h23) begin
            sel = 4'h4; imm = 32'($signed(s12));
        end else if (op == 7'h13) begin
            if (i[13:12] == 2'b01) begin
                sel = 4'hD; imm = (i >> 20) & 32'h1F;
            end else begin
                sel = 4'h2; imm = 32'($signed(i) >>> 20);
            end
        end else if (op == 7'h33 || op == 7'h73 || op == 7'h0F) begin
            sel = 4'h7; imm = 32'h0;
        end else begin
            sel = 4'h7; imm = 32'h0; ill = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        logic [3:0]  sel;
        logic [31:0] imm;
        logic        ill;
        check("out_valid", 32'(OUT_VALID), 32'(model_q.size() != 0));
        check("in_ready", 32'(IN_READY), 32'(model_q.size() < 2));
        if (model_q.size() != 0) begin
            ref_decode(model_q[0].inst, sel, imm, ill);
            check("inst_out", INST_OUT, model_q[0].inst);
            check("pc_out", PC_OUT, model_q[0].pc);
            check("imm_sel", 32'(IMM_SEL), 32'(sel));
            check("imm_out", IMM_OUT, imm);
            check("illegal", 32'(ILLEGAL), 32'(ill));
        end
    endtask

    // Called at a negedge: check, drive, advance one edge, update model, return at next negedge
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit do_push, do_pop;
        check_outputs();
        IN_VALID  = v;
        INST_IN   = inst;
        PC_IN     = pc;
        OUT_READY = rdy;
        FLUSH     = fl;
        do_push   = v && (model_q.size() < 2);
        do_pop    = rdy && (model_q.size() != 0);
        @(posedge CLK);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{inst: inst, pc: pc});
        end
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h63, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h13};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        INST_IN = 32'h0000_0093; PC_IN = 32'h100;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0; IN_VALID = 1'b0;
        check("rst_out_valid", 32'(OUT_VALID), 32'h0);
        check("rst_in_ready", 32'(IN_READY), 32'h1);
        check("rst_inst", INST_OUT, 32'h0000_0013);
        check("rst_pc", PC_OUT, 32'h0);
        check("rst_imm", IMM_OUT, 32'h0);
        check("rst_sel", 32'(IMM_SEL), 32'h7);
        check("rst_illegal", 32'(ILLEGAL), 32'h0);

        step(1, 32'h1234_50B7, 32'h1000, 1, 0);
        check("lui_sel", 32'(IMM_SEL), 32'h0);
        check("lui_imm", IMM_OUT, 32'h1234_5000);
        step(1, 32'hFE00_0EE3, 32'h1004, 1, 0);
        check("beq_sel", 32'(IMM_SEL), 32'h3);
        check("beq_imm", IMM_OUT, 32'hFFFF_FFFC);
        step(1, 32'h40F2_D293, 32'h1008, 1, 0);
        check("srai_sel", 32'(IMM_SEL), 32'hD);
        check("srai_imm", IMM_OUT, 32'h0000_000F);
        step(1, 32'hFFF0_0093, 32'h100C, 1, 0);
        check("addi_sel", 32'(IMM_SEL), 32'h2);
        check("addi_imm", IMM_OUT, 32'hFFFF_FFFF);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h0000_0013, 32'h2000, 0, 0);
        step(1, 32'h0010_0093, 32'h2004, 0, 0);
        check("bp_in_ready", 32'(IN_READY), 32'h0);
        check("bp_head", INST_OUT, 32'h0000_0013);
        step(1, 32'h0020_0093, 32'h2008, 0, 0);
        check("bp_head_hold", PC_OUT, 32'h2000);
        step(0, 32'h0, 32'h0, 1, 0);
        check("bp_second", PC_OUT, 32'h2004);
        step(0, 32'h0, 32'h0, 1, 0);
        check("bp_drained", 32'(OUT_VALID), 32'h0);
        check("bp_ready_back", 32'(IN_READY), 32'h1);

        step(1, 32'h0030_0093, 32'h3000, 0, 0);
        step(1, 32'h0040_0093, 32'h3004, 0, 0);
        step(1, 32'h0050_0093, 32'h3008, 1, 1);
        check("fl_out_valid", 32'(OUT_VALID), 32'h0);
        check("fl_in_ready", 32'(IN_READY), 32'h1);
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h0000_007F, 32'h4000, 0, 0);
        check("ill_flag", 32'(ILLEGAL), 32'h1);
        check("ill_sel", 32'(IMM_SEL), 32'h7);
        check("ill_imm", IMM_OUT, 32'h0);
        step(0, 32'h0, 32'h0, 1, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
